dram_to_bank_packer: RTL



---
 rtl/dram_to_bank_packer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dram_to_bank_packer.sv
// dram_to_bank_packer
// Packs a narrow DRAM beat stream into wide memory words (first beat in the
// MSBs) and writes them into NUM_BANKS banks of BANK_DEPTH words, generating
// the bank select and address itself in sequential or interleaved order.
// A start/flush/done sequence frames each fill; flush emits a zero-padded
// partial word when beats are pending.
module dram_to_bank_packer #(
    parameter int DATA_IN_BITWIDTH  = 8,
    parameter int DATA_OUT_BITWIDTH = 20,
    parameter int NUM_BANKS         = 2,
    parameter int BANK_DEPTH        = 4,
    parameter int BANK_MODE         = 0,
    localparam int AW = $clog2(BANK_DEPTH),
    localparam int WW = $clog2(NUM_BANKS*BANK_DEPTH+1)
) (
    input  logic                         clk_i,
    input  logic                         dram_to_bank_rst_i,
    input  logic                         start_i,
    input  logic                         flush_i,
    input  logic [DATA_IN_BITWIDTH-1:0]  data_in_i,
    input  logic                         data_valid_i,
    output logic                         data_ready_o,
    output logic [DATA_OUT_BITWIDTH-1:0] mem_data_o,
    output logic [AW-1:0]                mem_addr_o,
    output logic [NUM_BANKS-1:0]         mem_bank_sel_o,
    output logic                         mem_we_o,
    output logic [WW-1:0]                words_written_o,
    output logic                         done_o,
    output logic                         busy_o
);

    // beats per word, accumulator width, total capacity in words
    localparam int BEATS = (DATA_OUT_BITWIDTH + DATA_IN_BITWIDTH - 1) / DATA_IN_BITWIDTH;
    localparam int ACC   = BEATS * DATA_IN_BITWIDTH;
    localparam int CAP   = NUM_BANKS * BANK_DEPTH;
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int BKW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [ACC-1:0]               acc_q;
    logic [BCW-1:0]               beat_cnt_q;
    logic [AW-1:0]                addr_cnt_q;
    logic [BKW-1:0]               bank_cnt_q;
    logic [WW-1:0]                words_q;

    logic                         hs;
    logic                         beat_last;
    logic                         word_done;
    logic                         at_cap;
    logic                         start_ok;
    logic [ACC-1:0]               acc_shift;
    logic [ACC-1:0]               acc_pad;
    int                           pad_sh;
    logic                         wr_en;
    logic [DATA_OUT_BITWIDTH-1:0] wr_data;

    assign hs        = (state_q == S_FILL) && data_valid_i;
    assign beat_last = (beat_cnt_q == BCW'(BEATS - 1));
    assign word_done = hs && beat_last;
    assign at_cap    = (words_q == WW'(CAP - 1));
    assign start_ok  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

    // Incoming beat enters at the LSB end so earlier beats drift toward the MSBs.
    assign acc_shift = (acc_q << DATA_IN_BITWIDTH) | ACC'(data_in_i);

    // Partial word: slide pending beats up to the top, zeros fill the gap below.
    always_comb begin
        pad_sh  = (BEATS - int'(beat_cnt_q)) * DATA_IN_BITWIDTH;
        acc_pad = acc_q << pad_sh;
    end

    // Write request and the word to be written this cycle.
    always_comb begin
        wr_en   = word_done || ((state_q == S_FLUSH) && (beat_cnt_q != '0));
        wr_data = (state_q == S_FLUSH)
                ? DATA_OUT_BITWIDTH'(acc_pad   >> (ACC - DATA_OUT_BITWIDTH))
                : DATA_OUT_BITWIDTH'(acc_shift >> (ACC - DATA_OUT_BITWIDTH));
    end

    // State register.
    always_ff @(posedge clk_i or posedge dram_to_bank_rst_i) begin
        if (dram_to_bank_rst_i) state_q <= S_IDLE;
        else                    state_q <= state_d;
    end

    // Next-state: capacity takes priority over a coincident flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_FILL;
            S_FILL: begin
                if (word_done && at_cap) state_d = S_DONE;
                else if (flush_i)        state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  if (start_i) state_d = S_FILL;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded status outputs.
    always_comb begin
        data_ready_o = (state_q == S_FILL);
        done_o       = (state_q == S_DONE);
        busy_o       = (state_q == S_FILL) || (state_q == S_FLUSH);
    end

    // Beat accumulator and beat counter.
    always_ff @(posedge clk_i or posedge dram_to_bank_rst_i) begin
        if (dram_to_bank_rst_i) begin
            acc_q      <= '0;
            beat_cnt_q <= '0;
        end else if (start_ok || (state_q == S_FLUSH)) begin
            acc_q      <= '0;
            beat_cnt_q <= '0;
        end else if (hs) begin
            if (beat_last) begin
                acc_q      <= '0;
                beat_cnt_q <= '0;
            end else begin
                acc_q      <= acc_shift;
                beat_cnt_q <= beat_cnt_q + BCW'(1);
            end
        end
    end

    // Address, bank and word counters; they hold the slot for the next word.
    always_ff @(posedge clk_i or posedge dram_to_bank_rst_i) begin
        if (dram_to_bank_rst_i) begin
            addr_cnt_q <= '0;
            bank_cnt_q <= '0;
            words_q    <= '0;
        end else if (start_ok) begin
            addr_cnt_q <= '0;
            bank_cnt_q <= '0;
            words_q    <= '0;
        end else if (wr_en) begin
            words_q <= words_q + WW'(1);
            if (BANK_MODE == 0) begin
                // sequential: walk addresses, step bank on address wrap
                if (addr_cnt_q == AW'(BANK_DEPTH - 1)) begin
                    addr_cnt_q <= '0;
                    bank_cnt_q <= (bank_cnt_q == BKW'(NUM_BANKS - 1)) ? '0 : bank_cnt_q + BKW'(1);
                end else begin
                    addr_cnt_q <= addr_cnt_q + AW'(1);
                end
            end else begin
                // interleaved: walk banks, step address on bank wrap
                if (bank_cnt_q == BKW'(NUM_BANKS - 1)) begin
                    bank_cnt_q <= '0;
                    addr_cnt_q <= (addr_cnt_q == AW'(BANK_DEPTH - 1)) ? '0 : addr_cnt_q + AW'(1);
                end else begin
                    bank_cnt_q <= bank_cnt_q + BKW'(1);
                end
            end
        end
    end

    // Registered write port; strobe and select live for exactly one cycle.
    always_ff @(posedge clk_i or posedge dram_to_bank_rst_i) begin
        if (dram_to_bank_rst_i) begin
            mem_we_o       <= 1'b0;
            mem_bank_sel_o <= '0;
            mem_data_o     <= '0;
            mem_addr_o     <= '0;
        end else begin
            mem_we_o       <= wr_en;
            mem_bank_sel_o <= wr_en ? (NUM_BANKS'(1) << bank_cnt_q) : '0;
            if (wr_en) begin
                mem_data_o <= wr_data;
                mem_addr_o <= addr_cnt_q;
            end
        end
    end

    assign words_written_o = words_q;

endmodule
